// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_pkg
// Purpose  : Shared encodings for the fetch sequencer.
//            - NPC_* : next-PC operation codes coming from the EX stage.
//            - FS_*  : fetch FSM state encodings.
//            - npc_is_redirect() : true for the ops that change control flow.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

  // Next-PC operation codes (unchanged from the existing control encoding)
  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  // Fetch FSM states
  localparam logic [1:0] FS_BOOT = 2'd0;
  localparam logic [1:0] FS_REQ  = 2'd1;
  localparam logic [1:0] FS_RESP = 2'd2;
  localparam logic [1:0] FS_DROP = 2'd3;

  // Undefined opcodes are treated like NPC_PLUS4, i.e. no redirect.
  function automatic logic npc_is_redirect(input logic [2:0] op);
    return (op == NPC_BRANCH) || (op == NPC_JUMP) || (op == NPC_JALR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_if
// Purpose  : Instruction-memory request/response bus.
// Ports    : req    - fetch request            (master -> slave)
//            addr   - fetch address            (master -> slave)
//            gnt    - request accepted         (slave -> master)
//            rvalid - instruction returned     (slave -> master)
//            rdata  - returned instruction     (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer_pc_target_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_target_unit
// Purpose  : Combinational redirect decision and target address.
//            Priority: trap > EX branch/jump/jalr > sequential.
// Ports    : trap_i, ex_npcop, ex_pc, ex_imm, ex_rs1 - inputs
//            redirect - a redirect is requested this cycle
//            target   - redirect destination (JALR result has LSB cleared)
// Revision : 1.0 - initial release
// ============================================================================
module pc_target_unit
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        trap_i,
  input  logic [2:0]  ex_npcop,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  output logic        redirect,
  output logic [31:0] target
);

  logic [31:0] w_pc_rel;
  logic [31:0] w_reg_rel;

  assign w_pc_rel  = ex_pc + ex_imm;
  assign w_reg_rel = (ex_rs1 + ex_imm) & ~32'h1;
  assign redirect  = trap_i | npc_is_redirect(ex_npcop);

  always_comb begin
    target = 32'h0;
    if (trap_i)
      target = TRAP_VEC;
    else if (ex_npcop == NPC_JALR)
      target = w_reg_rel;
    else if ((ex_npcop == NPC_BRANCH) || (ex_npcop == NPC_JUMP))
      target = w_pc_rel;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Owns the PC and sequences instruction fetch, one outstanding
//            request at a time. Handles redirects, squashes stale returns and
//            parks a return that arrives during a stall in a 1-entry buffer.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            stall_i           - pipeline stall
//            trap_i            - trap redirect request
//            ex_npcop/pc/imm/rs1 - EX-stage next-PC information
//            imem              - instruction memory bus (master side)
//            if_valid/instr/pc - instruction delivered to IF/ID
//            flush_ifid/idex   - pipeline kills, asserted with a redirect
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  input  logic                      trap_i,
  input  logic [2:0]                ex_npcop,
  input  logic [31:0]               ex_pc,
  input  logic [31:0]               ex_imm,
  input  logic [31:0]               ex_rs1,
  fetch_sequencer_if.master         imem,
  output logic                      if_valid,
  output logic [31:0]               if_instr,
  output logic [31:0]               if_pc,
  output logic                      flush_ifid,
  output logic                      flush_idex
);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ftch_pc;
  logic        r_hold_valid;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_fire;
  logic        w_drain;
  logic        w_deliver;

  pc_target_unit #(.TRAP_VEC(TRAP_VEC)) u_pc_target (
    .trap_i   (trap_i),
    .ex_npcop (ex_npcop),
    .ex_pc    (ex_pc),
    .ex_imm   (ex_imm),
    .ex_rs1   (ex_rs1),
    .redirect (w_redirect),
    .target   (w_target)
  );

  assign flush_ifid = w_redirect;
  assign flush_idex = w_redirect;

  // A full hold buffer blocks new requests, so the buffer can only be
  // occupied while sitting in REQ; draining therefore never races a fetch.
  assign imem.req  = (r_state == FS_REQ) & ~stall_i & ~r_hold_valid;
  assign imem.addr = r_pc;
  assign w_fire    = imem.req & imem.gnt;

  assign w_drain   = (r_state == FS_REQ) & r_hold_valid & ~stall_i & ~w_redirect;
  assign w_deliver = (r_state == FS_RESP) & imem.rvalid & ~stall_i & ~w_redirect;

  assign if_valid  = w_drain | w_deliver;
  assign if_instr  = w_deliver ? imem.rdata : (w_drain ? r_hold_instr : 32'h0);
  assign if_pc     = w_deliver ? r_ftch_pc  : (w_drain ? r_hold_pc    : 32'h0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FS_BOOT;
      r_pc         <= RESET_PC;
      r_ftch_pc    <= RESET_PC;
      r_hold_valid <= 1'b0;
      r_hold_instr <= 32'h0;
      r_hold_pc    <= 32'h0;
    end else begin
      // A redirect makes any parked instruction stale.
      if (w_redirect || w_drain)
        r_hold_valid <= 1'b0;

      case (r_state)
        FS_BOOT: begin
          if (w_redirect) r_pc <= w_target;
          r_state <= FS_REQ;
        end
        FS_REQ: begin
          if (w_redirect) begin
            r_pc <= w_target;
            // A granted fetch to the old PC still returns; squash it.
            if (w_fire) r_state <= FS_DROP;
          end else if (w_fire) begin
            r_ftch_pc <= r_pc;
            r_pc      <= r_pc + 32'd4;
            r_state   <= FS_RESP;
          end
        end
        FS_RESP: begin
          if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= imem.rvalid ? FS_REQ : FS_DROP;
          end else if (imem.rvalid) begin
            r_state <= FS_REQ;
            if (stall_i) begin
              r_hold_valid <= 1'b1;
              r_hold_instr <= imem.rdata;
              r_hold_pc    <= r_ftch_pc;
            end
          end
        end
        FS_DROP: begin
          if (w_redirect) r_pc <= w_target;
          if (imem.rvalid) r_state <= FS_REQ;
        end
        default: r_state <= FS_BOOT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Directed testbench for fetch_sequencer with hand-computed
//            expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        trap_i;
  logic [2:0]  ex_npcop;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush_ifid;
  logic        flush_idex;

  int n_total = 0;
  int n_bad   = 0;

  fetch_sequencer_if imem_bus ();

  fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .TRAP_VEC (32'h0000_0100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .trap_i     (trap_i),
    .ex_npcop   (ex_npcop),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .ex_rs1     (ex_rs1),
    .imem       (imem_bus.master),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .flush_ifid (flush_ifid),
    .flush_idex (flush_idex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let inputs be driven.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_ex();
    trap_i   = 1'b0;
    ex_npcop = NPC_PLUS4;
    ex_pc    = 32'h0;
    ex_imm   = 32'h0;
    ex_rs1   = 32'h0;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0;
    clear_ex();
    imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = 32'h0;
    tick(); tick();
    settle();
    chk("rst_req",   {31'h0, imem_bus.req}, 32'h0);
    chk("rst_addr",  imem_bus.addr,          32'h0);
    chk("rst_valid", {31'h0, if_valid},      32'h0);
    chk("rst_flush", {30'h0, flush_ifid, flush_idex}, 32'h0);

    // BOOT cycle
    rst = 1'b0;
    settle();
    chk("boot_req", {31'h0, imem_bus.req}, 32'h0);
    tick();

    // ---- 1: sequential fetch ----
    imem_bus.gnt = 1'b1; settle();
    chk("t1_req0",  {31'h0, imem_bus.req}, 32'h1);
    chk("t1_addr0", imem_bus.addr,          32'h0);
    tick();
    imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'h11; settle();
    chk("t1_req_resp", {31'h0, imem_bus.req}, 32'h0);
    chk("t1_val0",  {31'h0, if_valid}, 32'h1);
    chk("t1_pc0",   if_pc,             32'h0);
    chk("t1_ins0",  if_instr,          32'h11);
    tick();
    imem_bus.rvalid = 1'b0; imem_bus.gnt = 1'b1; settle();
    chk("t1_addr4", imem_bus.addr, 32'h4);
    chk("t1_gap",   {31'h0, if_valid}, 32'h0);
    tick();
    imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'h22; settle();
    chk("t1_pc4",   if_pc, 32'h4);
    tick();
    imem_bus.rvalid = 1'b0; settle();
    chk("t1_addr8", imem_bus.addr, 32'h8);

    // ---- 2: JUMP while in REQ, not granted ----
    ex_npcop = NPC_JUMP; ex_pc = 32'h40; ex_imm = 32'h20; settle();
    chk("t2_flush_ifid", {31'h0, flush_ifid}, 32'h1);
    chk("t2_flush_idex", {31'h0, flush_idex}, 32'h1);
    tick();
    clear_ex(); imem_bus.gnt = 1'b1; settle();
    chk("t2_flush_off", {31'h0, flush_ifid}, 32'h0);
    chk("t2_addr",      imem_bus.addr,        32'h60);
    chk("t2_req",       {31'h0, imem_bus.req}, 32'h1);
    tick();

    // ---- 3: JALR while the response is pending ----
    imem_bus.gnt = 1'b0;
    ex_npcop = NPC_JALR; ex_rs1 = 32'h1003; ex_imm = 32'h4; settle();
    chk("t3_flush", {31'h0, flush_idex}, 32'h1);
    tick();
    clear_ex(); imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'hBAD; settle();
    chk("t3_stale_valid", {31'h0, if_valid}, 32'h0);
    chk("t3_drop_req",    {31'h0, imem_bus.req}, 32'h0);
    tick();
    imem_bus.rvalid = 1'b0; imem_bus.gnt = 1'b1; settle();
    chk("t3_req",  {31'h0, imem_bus.req}, 32'h1);
    chk("t3_addr", imem_bus.addr, 32'h1006);
    tick();
    imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'h33; settle();
    chk("t3_pc", if_pc, 32'h1006);
    tick();
    imem_bus.rvalid = 1'b0;

    // ---- 4: trap and branch in the same cycle ----
    trap_i = 1'b1; ex_npcop = NPC_BRANCH; ex_pc = 32'h200; ex_imm = 32'h10; settle();
    chk("t4_flush", {31'h0, flush_ifid}, 32'h1);
    tick();
    clear_ex(); imem_bus.gnt = 1'b1; settle();
    chk("t4_addr", imem_bus.addr, 32'h100);
    tick();
    imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'h44; settle();
    chk("t4_pc", if_pc, 32'h100);
    tick();
    imem_bus.rvalid = 1'b0;

    // ---- 5: return during stall goes to hold buffer ----
    ex_npcop = NPC_JUMP; ex_pc = 32'h0; ex_imm = 32'h8;
    tick();
    clear_ex(); imem_bus.gnt = 1'b1; settle();
    chk("t5_addr8", imem_bus.addr, 32'h8);
    tick();
    imem_bus.gnt = 1'b0; stall_i = 1'b1;
    imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'hDEADBEEF; settle();
    chk("t5_stall_valid0", {31'h0, if_valid}, 32'h0);
    tick();
    imem_bus.rvalid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      settle();
      chk("t5_stall_valid", {31'h0, if_valid},     32'h0);
      chk("t5_stall_req",   {31'h0, imem_bus.req}, 32'h0);
      tick();
    end
    stall_i = 1'b0; settle();
    chk("t5_drain_valid", {31'h0, if_valid},     32'h1);
    chk("t5_drain_instr", if_instr,               32'hDEADBEEF);
    chk("t5_drain_pc",    if_pc,                  32'h8);
    chk("t5_drain_req",   {31'h0, imem_bus.req}, 32'h0);
    tick();
    imem_bus.gnt = 1'b1; settle();
    chk("t5_after_req",  {31'h0, imem_bus.req}, 32'h1);
    chk("t5_after_addr", imem_bus.addr,          32'hC);
    tick();
    // fill the buffer again, then redirect while still stalled
    imem_bus.gnt = 1'b0; stall_i = 1'b1; imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'h55;
    tick();
    imem_bus.rvalid = 1'b0;
    ex_npcop = NPC_JUMP; ex_pc = 32'h300; ex_imm = 32'h0; settle();
    chk("t5_redir_flush", {31'h0, flush_ifid}, 32'h1);
    chk("t5_redir_valid", {31'h0, if_valid},   32'h0);
    tick();
    clear_ex(); stall_i = 1'b0; settle();
    chk("t5_dropped_valid", {31'h0, if_valid},     32'h0);
    chk("t5_dropped_req",   {31'h0, imem_bus.req}, 32'h1);
    chk("t5_dropped_addr",  imem_bus.addr,          32'h300);

    // ---- 6: reset while a response is outstanding ----
    imem_bus.gnt = 1'b1;
    tick();
    imem_bus.gnt = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'h66; settle();
    chk("t6_ignored", {31'h0, if_valid},     32'h0);
    chk("t6_boot_req", {31'h0, imem_bus.req}, 32'h0);
    tick();
    imem_bus.rvalid = 1'b0; settle();
    chk("t6_req",  {31'h0, imem_bus.req}, 32'h1);
    chk("t6_addr", imem_bus.addr,          32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
